trap_sequencer: RTL and testbench

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer_pkg.sv | 36 +++
 rtl/trap_sequencer_if.sv | 23 ++
 rtl/trap_sequencer_irq_prio_enc.sv | 26 ++
 rtl/trap_sequencer.sv | 140 ++++++++++++++
 tb/tb_trap_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the trap sequencer: system-op codes, interrupt codes,
// and the sequencer state encoding.
package trap_sequencer_pkg;

    // System-op codes presented by decode, plus the sequencer-generated ones
    localparam logic [4:0] SYSOP_NONE   = 5'd0;
    localparam logic [4:0] SYSOP_ECALL  = 5'd1;
    localparam logic [4:0] SYSOP_EBREAK = 5'd2;
    localparam logic [4:0] SYSOP_MRET   = 5'd3;
    localparam logic [4:0] SYSOP_WFI    = 5'd4;
    localparam logic [4:0] SYSOP_CSR_W  = 5'd8;
    localparam logic [4:0] SYSOP_CSR_S  = 5'd9;
    localparam logic [4:0] SYSOP_CSR_C  = 5'd10;
    localparam logic [4:0] SYSOP_IRQ    = 5'd16;

    // Machine interrupt codes reported in tval
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

    // tval reported for a non-maskable interrupt
    localparam logic [63:0] NMI_TVAL = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN
    } seq_state_e;

    // CSR accesses complete without a pipeline redirect
    function automatic logic is_csr_op(input logic [4:0] c);
        return (c == SYSOP_CSR_W) || (c == SYSOP_CSR_S) || (c == SYSOP_CSR_C);
    endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Decode/exception-unit handshake bundle seen by the trap sequencer.
// master = decode + exception unit side, slave = sequencer.
interface trap_sequencer_if;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [63:0] exc_pc;
    logic [63:0] exc_tval;
    logic        exc_ready;
    logic        trap_en;
    logic [4:0]  cause;
    logic [63:0] pc;
    logic [63:0] tval;

    modport master (
        output exc_valid, exc_cause, exc_pc, exc_tval, trap_en,
        input  exc_ready, cause, pc, tval
    );

    modport slave (
        input  exc_valid, exc_cause, exc_pc, exc_tval, trap_en,
        output exc_ready, cause, pc, tval
    );
endinterface

// File: rtl/trap_sequencer_irq_prio_enc.sv
// Fixed-priority interrupt select: MEI over MSI over MTI.
module irq_prio_enc
    import trap_sequencer_pkg::*;
(
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [3:0] code
);

    // Highest-priority pending request wins; one-hot grant plus its code
    always_comb begin
        grant = 3'b000;
        code  = 4'd0;
        if (req[2]) begin
            grant = 3'b100;
            code  = IRQ_CODE_MEI;
        end else if (req[0]) begin
            grant = 3'b001;
            code  = IRQ_CODE_MSI;
        end else if (req[1]) begin
            grant = 3'b010;
            code  = IRQ_CODE_MTI;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap sequencer: accepts system ops and interrupts in IDLE, issues one
// registered request to the exception unit, waits for the redirect and
// holds the front end stalled for DRAIN_CYCLES refill cycles.
// Optional feature macro: TRAP_SEQ_NMI_EN adds an edge-triggered nmi input.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    trap_sequencer_if.slave  bus,
    input  logic [2:0]       irq_src,
    input  logic [2:0]       irq_mask,
    input  logic             glob_ie,
`ifdef TRAP_SEQ_NMI_EN
    input  logic             nmi,
`endif
    output logic             stall,
    output logic [2:0]       irq_taken
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    seq_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  cause_q, ld_cause;
    logic [63:0] pc_q, ld_pc;
    logic [63:0] tval_q, ld_tval;
    logic [2:0]  taken_d;
    logic [2:0]  irq_req;
    logic [2:0]  irq_grant;
    logic [3:0]  irq_code;

    assign irq_req = irq_src & irq_mask;

    irq_prio_enc u_prio (
        .req   (irq_req),
        .grant (irq_grant),
        .code  (irq_code)
    );

`ifdef TRAP_SEQ_NMI_EN
    logic nmi_d_q, nmi_pend_q, nmi_edge, nmi_take;
    assign nmi_edge = nmi & ~nmi_d_q;

    // Remember an nmi rising edge until it is issued; a same-cycle edge counts
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_d_q    <= 1'b0;
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_d_q    <= nmi;
            nmi_pend_q <= (nmi_pend_q | nmi_edge) & ~nmi_take;
        end
    end
`endif

    // Next-state and request selection; request fields are zero unless issuing
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_cause = SYSOP_NONE;
        ld_pc    = '0;
        ld_tval  = '0;
        taken_d  = 3'b000;
`ifdef TRAP_SEQ_NMI_EN
        nmi_take = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef TRAP_SEQ_NMI_EN
                if (nmi_pend_q | nmi_edge) begin
                    nmi_take = 1'b1;
                    ld_cause = SYSOP_IRQ;
                    ld_pc    = bus.exc_pc;
                    ld_tval  = NMI_TVAL;
                    state_d  = ST_ISSUE;
                end else
`endif
                if (bus.exc_valid) begin
                    ld_cause = bus.exc_cause;
                    ld_pc    = bus.exc_pc;
                    ld_tval  = bus.exc_tval;
                    state_d  = ST_ISSUE;
                end else if (glob_ie && (irq_req != 3'b000)) begin
                    ld_cause = SYSOP_IRQ;
                    ld_pc    = bus.exc_pc;
                    ld_tval  = {60'd0, irq_code};
                    taken_d  = irq_grant;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = is_csr_op(cause_q) ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.trap_en) begin
                    cnt_d   = DRAIN_LOAD;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, drain counter and the one-cycle registered request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            cause_q   <= SYSOP_NONE;
            pc_q      <= '0;
            tval_q    <= '0;
            irq_taken <= 3'b000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= ld_cause;
            pc_q      <= ld_pc;
            tval_q    <= ld_tval;
            irq_taken <= taken_d;
        end
    end

    assign bus.exc_ready = (state_q == ST_IDLE);
    assign stall         = (state_q != ST_IDLE);
    assign bus.cause     = cause_q;
    assign bus.pc        = pc_q;
    assign bus.tval      = tval_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios followed by randomized traffic,
// every cycle compared against a timestamp-based reference model.
module tb_trap_sequencer;
    import trap_sequencer_pkg::*;

    localparam int DRAIN = 2;
    localparam int NEVER = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] irq_src, irq_mask;
    logic       glob_ie;
    logic       stall;
    logic [2:0] irq_taken;
`ifdef TRAP_SEQ_NMI_EN
    logic       nmi;
`endif

    trap_sequencer_if bus();

    trap_sequencer #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .irq_src   (irq_src),
        .irq_mask  (irq_mask),
        .glob_ie   (glob_ie),
`ifdef TRAP_SEQ_NMI_EN
        .nmi       (nmi),
`endif
        .stall     (stall),
        .irq_taken (irq_taken)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: a transaction occupies the sequencer from acceptance
    // until a known free cycle; the request is visible only in its issue cycle.
    bit          m_busy = 0, m_csr = 0, m_redir = 0, m_took_exc = 0;
    bit          m_pend = 0, m_nmi_prev = 0;
    int          m_iss = -1, m_free = 0;
    logic [4:0]  m_cause;
    logic [63:0] m_pc, m_tval;
    logic [2:0]  m_taken;
    logic        e_ready, e_stall;
    logic [4:0]  e_cause;
    logic [63:0] e_pc, e_tval;
    logic [2:0]  e_taken;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge();
        bit idle_now, take, nmi_want;
        int order[3] = '{2, 0, 1};
        int codes[3] = '{11, 3, 7};
        logic [2:0] elig;
        m_took_exc = 0;
        nmi_want = 0;
        if (rst) begin
            m_busy = 0; m_redir = 0; m_pend = 0; m_nmi_prev = 0; m_iss = -1;
        end else begin
            idle_now = !m_busy || (cyc >= m_free);
            if (idle_now) m_busy = 0;
`ifdef TRAP_SEQ_NMI_EN
            nmi_want = m_pend || (nmi && !m_nmi_prev);
            m_nmi_prev = nmi;
            m_pend = nmi_want && !idle_now;
`endif
            take = 0;
            m_taken = 3'b000;
            elig = irq_src & irq_mask;
            if (idle_now) begin
                if (nmi_want) begin
                    take = 1; m_cause = SYSOP_IRQ; m_pc = bus.exc_pc;
                    m_tval = 64'h8000_0000_0000_0000;
                end else if (bus.exc_valid) begin
                    take = 1; m_took_exc = 1;
                    m_cause = bus.exc_cause; m_pc = bus.exc_pc; m_tval = bus.exc_tval;
                end else if (glob_ie && elig != 3'b000) begin
                    take = 1; m_cause = SYSOP_IRQ; m_pc = bus.exc_pc;
                    for (int k = 2; k >= 0; k--)
                        if (elig[order[k]]) begin
                            m_tval = 64'(codes[k]);
                            m_taken = 3'b000;
                            m_taken[order[k]] = 1'b1;
                        end
                end
            end
            if (take) begin
                m_busy = 1; m_iss = cyc + 1; m_redir = 0;
                m_csr  = (m_cause == SYSOP_CSR_W) || (m_cause == SYSOP_CSR_S) ||
                         (m_cause == SYSOP_CSR_C);
                m_free = m_csr ? cyc + 2 : NEVER;
            end else if (m_busy && !m_csr && !m_redir && cyc > m_iss && bus.trap_en) begin
                m_redir = 1;
                m_free  = cyc + 1 + DRAIN;
            end
        end
        e_ready = !m_busy || ((cyc + 1) >= m_free);
        e_stall = !e_ready;
        if (m_busy && m_iss == cyc + 1) begin
            e_cause = m_cause; e_pc = m_pc; e_tval = m_tval; e_taken = m_taken;
        end else begin
            e_cause = '0; e_pc = '0; e_tval = '0; e_taken = '0;
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("exc_ready", 64'(bus.exc_ready), 64'(e_ready));
        check("stall",     64'(stall),         64'(e_stall));
        check("cause",     64'(bus.cause),     64'(e_cause));
        check("pc",        bus.pc,             e_pc);
        check("tval",      bus.tval,           e_tval);
        check("irq_taken", 64'(irq_taken),     64'(e_taken));
    endtask

    task automatic quiet();
        rst = 0; bus.exc_valid = 0; bus.exc_cause = '0; bus.exc_pc = '0;
        bus.exc_tval = '0; bus.trap_en = 0; irq_src = '0; irq_mask = '0; glob_ie = 0;
`ifdef TRAP_SEQ_NMI_EN
        nmi = 0;
`endif
    endtask

    task automatic present(input logic [4:0] c, input logic [63:0] p, input logic [63:0] t);
        bus.exc_valid = 1; bus.exc_cause = c; bus.exc_pc = p; bus.exc_tval = t;
    endtask

    task automatic redirect_and_drain();
        bus.trap_en = 1; step();
        bus.trap_en = 0;
        for (int i = 1; i < DRAIN; i++) step();
        step();
    endtask

    logic [4:0] causes[6];

    initial begin
        causes = '{SYSOP_ECALL, SYSOP_EBREAK, SYSOP_MRET, SYSOP_CSR_W, SYSOP_CSR_S, SYSOP_CSR_C};
        quiet();
        rst = 1; step(); step();
        check("rst_ready", 64'(bus.exc_ready), 64'd1);
        check("rst_stall", 64'(stall), 64'd0);
        rst = 0;

        // ECALL, redirect after one wait cycle, two drain cycles
        present(SYSOP_ECALL, 64'h1000, 64'h0); step();
        check("ecall_cause", 64'(bus.cause), 64'(SYSOP_ECALL));
        check("ecall_pc", bus.pc, 64'h1000);
        bus.exc_valid = 0; step();
        check("wait_cause", 64'(bus.cause), 64'd0);
        bus.trap_en = 1; step();
        check("drain1_stall", 64'(stall), 64'd1);
        bus.trap_en = 0; step();
        check("drain2_stall", 64'(stall), 64'd1);
        step();
        check("after_drain_ready", 64'(bus.exc_ready), 64'd1);

        // CSR set: one issue cycle then straight back to idle
        present(SYSOP_CSR_S, 64'h2000, 64'h300); step();
        check("csr_tval", bus.tval, 64'h300);
        bus.exc_valid = 0; step();
        check("csr_ready", 64'(bus.exc_ready), 64'd1);

        // Interrupt priority with masking, then globally disabled
        irq_src = 3'b111; irq_mask = 3'b101; glob_ie = 1; step();
        check("irq_tval", bus.tval, 64'd11);
        check("irq_taken", 64'(irq_taken), 64'(3'b100));
        irq_src = 3'b000; step();
        redirect_and_drain();
        glob_ie = 0; irq_src = 3'b111; step(); step();
        check("gie_off_stall", 64'(stall), 64'd0);
        irq_src = 3'b000;

        // Exception beats a same-cycle timer interrupt; timer follows the drain
        glob_ie = 1; irq_src = 3'b010; irq_mask = 3'b010;
        present(SYSOP_ECALL, 64'h3000, 64'h0); step();
        check("race_cause", 64'(bus.cause), 64'(SYSOP_ECALL));
        bus.exc_valid = 0; step();
        redirect_and_drain();
        step();
        check("race_mti_tval", bus.tval, 64'd7);
        irq_src = 3'b000; step();
        redirect_and_drain();

        // Reset while waiting for the redirect; later trap_en is ignored
        present(SYSOP_EBREAK, 64'h4000, 64'h55); step();
        bus.exc_valid = 0; step();
        rst = 1; step();
        check("rst_wait_cause", 64'(bus.cause), 64'd0);
        check("rst_wait_ready", 64'(bus.exc_ready), 64'd1);
        rst = 0; bus.trap_en = 1; step();
        check("late_trap_stall", 64'(stall), 64'd0);
        bus.trap_en = 0;

`ifdef TRAP_SEQ_NMI_EN
        // NMI edge beats a waiting ECALL, which is accepted after the drain
        present(SYSOP_ECALL, 64'h5000, 64'h0); nmi = 1; step();
        check("nmi_tval", bus.tval, 64'h8000_0000_0000_0000);
        step();
        redirect_and_drain();
        step();
        check("nmi_then_ecall", 64'(bus.cause), 64'(SYSOP_ECALL));
        bus.exc_valid = 0; nmi = 0; step();
        redirect_and_drain();
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (bus.exc_valid && m_took_exc) bus.exc_valid = 0;
            if (!bus.exc_valid && $urandom_range(0, 3) == 0)
                present(causes[$urandom_range(0, 5)], {$urandom, $urandom}, {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) irq_src = 3'($urandom);
            irq_mask = 3'($urandom);
            glob_ie = 1'($urandom_range(0, 1));
            bus.trap_en = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 79) == 0);
`ifdef TRAP_SEQ_NMI_EN
            if ($urandom_range(0, 15) == 0) nmi = ~nmi;
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
